// File: rtl/issue_bru_fifo_if.sv
// Shared types and the handshake interface between issue, the issue->BRU
// queue and execute_bru.
//
// issue_bru_fifo_pkg : issue_execute_pack_t and branch op encodings.
// issue_bru_fifo_if  : push/pop/flush handshake plus queue status.
//   master modport : issue / execute_bru / commit side (drives push, pop,
//                    flush and data_in).
//   slave modport  : the queue itself (drives full, data_out,
//                    data_out_valid and count).

package issue_bru_fifo_pkg;

    typedef enum logic [4:0] {
        OP_JAL  = 5'd0,
        OP_JALR = 5'd1,
        OP_BEQ  = 5'd2,
        OP_BNE  = 5'd3,
        OP_BLT  = 5'd4,
        OP_BGE  = 5'd5,
        OP_BLTU = 5'd6,
        OP_BGEU = 5'd7
    } bru_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        bru_op_t     op;
        logic [5:0]  checkpoint_id;
        logic [4:0]  rd;
    } issue_execute_pack_t;

endpackage

interface issue_bru_fifo_if #(
    parameter int DEPTH = 4
);
    import issue_bru_fifo_pkg::*;

    localparam int DEPTH_WIDTH = $clog2(DEPTH);

    logic                   issue_bru_fifo_flush;
    issue_execute_pack_t    issue_bru_fifo_data_in;
    logic                   issue_bru_fifo_push;
    logic                   issue_bru_fifo_full;
    issue_execute_pack_t    issue_bru_fifo_data_out;
    logic                   issue_bru_fifo_data_out_valid;
    logic                   issue_bru_fifo_pop;
    logic [DEPTH_WIDTH:0]   issue_bru_fifo_count;

    modport master (
        output issue_bru_fifo_flush,
        output issue_bru_fifo_data_in,
        output issue_bru_fifo_push,
        output issue_bru_fifo_pop,
        input  issue_bru_fifo_full,
        input  issue_bru_fifo_data_out,
        input  issue_bru_fifo_data_out_valid,
        input  issue_bru_fifo_count
    );

    modport slave (
        input  issue_bru_fifo_flush,
        input  issue_bru_fifo_data_in,
        input  issue_bru_fifo_push,
        input  issue_bru_fifo_pop,
        output issue_bru_fifo_full,
        output issue_bru_fifo_data_out,
        output issue_bru_fifo_data_out_valid,
        output issue_bru_fifo_count
    );

endinterface

// File: rtl/issue_bru_fifo.sv
// Show-ahead queue between the issue stage and execute_bru.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (pointers only, storage kept)
//   bus  : issue_bru_fifo_if slave modport
//          push/data_in from issue, pop from execute_bru, flush from commit;
//          full, data_out (head), data_out_valid and count back.
//
// All outputs are decoded from the registered pointers and storage only,
// so there is no combinational path from any input to any output.
// Parameters ASSERT_NO_PUSH_FULL / ASSERT_NO_POP_EMPTY enable the
// simulation-only protocol checks.

module issue_bru_fifo #(
    parameter int DEPTH               = 4,
    parameter bit ASSERT_NO_PUSH_FULL = 1'b1,
    parameter bit ASSERT_NO_POP_EMPTY = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    issue_bru_fifo_if.slave bus
);
    import issue_bru_fifo_pkg::*;

    localparam int DEPTH_WIDTH = $clog2(DEPTH);

    issue_execute_pack_t    mem_reg [DEPTH];
    logic [DEPTH_WIDTH:0]   rptr_reg;
    logic [DEPTH_WIDTH:0]   wptr_reg;

    logic empty;
    logic full;
    logic push_ok;
    logic pop_ok;

    assign empty = (rptr_reg == wptr_reg);
    // Same index but opposite wrap bit: writer is exactly one lap ahead.
    assign full  = (rptr_reg[DEPTH_WIDTH-1:0] == wptr_reg[DEPTH_WIDTH-1:0]) &&
                   (rptr_reg[DEPTH_WIDTH] != wptr_reg[DEPTH_WIDTH]);

    // Flush kills both sides; full/empty are judged on current state only,
    // so a pop does not make room for a same-cycle push.
    assign push_ok = bus.issue_bru_fifo_push && !full  && !bus.issue_bru_fifo_flush;
    assign pop_ok  = bus.issue_bru_fifo_pop  && !empty && !bus.issue_bru_fifo_flush;

    always_ff @(posedge clk) begin
        if (rst || bus.issue_bru_fifo_flush) begin
            rptr_reg <= '0;
            wptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
        end
    end

    // Storage has no reset; stale contents are masked by the empty check.
    // A write during rst is harmless because the pointers return to 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wptr_reg[DEPTH_WIDTH-1:0]] <= bus.issue_bru_fifo_data_in;
        end
    end

    assign bus.issue_bru_fifo_full           = full;
    assign bus.issue_bru_fifo_data_out_valid = !empty;
    assign bus.issue_bru_fifo_data_out       = empty ? '0 : mem_reg[rptr_reg[DEPTH_WIDTH-1:0]];
    // Modulo subtraction on the wrap-extended pointers gives 0..DEPTH.
    assign bus.issue_bru_fifo_count          = wptr_reg - rptr_reg;

    always_ff @(posedge clk) begin
        if (!rst && !bus.issue_bru_fifo_flush) begin
            if (ASSERT_NO_PUSH_FULL) begin
                assert (!(bus.issue_bru_fifo_push && full));
            end
            if (ASSERT_NO_POP_EMPTY) begin
                assert (!(bus.issue_bru_fifo_pop && empty));
            end
        end
    end

endmodule
